// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its fetch sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Instruction-fetch and data-memory handshake between the hazard controller and the memories.
interface hazard_ctrl_if;

    logic ImemReq;
    logic ImemAccept;
    logic ImemReady;
    logic DmemReq;
    logic DmemReady;

    modport master (
        output ImemReq,
        output ImemAccept,
        input  ImemReady,
        input  DmemReq,
        input  DmemReady
    );

    modport slave (
        input  ImemReq,
        input  ImemAccept,
        output ImemReady,
        output DmemReq,
        output DmemReady
    );

endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: tracks whether the outstanding instruction word is wanted or must be discarded.
module fetch_seq
    import hazard_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ImemReady,
    input  logic PCSrcE,
    input  logic mem_stall,
    input  logic lw_stall,
    output logic imem_req,
    output logic imem_accept,
    output logic fetch_wait
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: state_next = REQ;
            // A redirect while the old word is still in flight means that word must be thrown away.
            REQ: begin
                if (!ImemReady && PCSrcE && !mem_stall) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (ImemReady) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req    = (state_reg != IDLE);
    assign fetch_wait  = (state_reg != REQ) || !ImemReady;
    assign imem_accept = ImemReady &&
                         ((state_reg == DISCARD) ||
                          ((state_reg == REQ) && !mem_stall && !lw_stall));

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, stalls, flushes and fetch sequencing.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    hazard_ctrl_if.master    bus,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] RedirectCount
);

    logic             mem_stall;
    logic             lw_stall;
    logic             fetch_wait;
    logic             imem_req;
    logic             imem_accept;
    logic [REG_W-1:0] rs_e [2];
    logic [1:0]       fwd  [2];

    assign mem_stall = bus.DmemReq && !bus.DmemReady;
    assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // The M-stage result is younger than the W-stage one, so it wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = (RegWriteM && (RdM != '0) && (RdM == rs_e[gi])) ? FWD_MEM :
                             (RegWriteW && (RdW != '0) && (RdW == rs_e[gi])) ? FWD_WB  :
                                                                               FWD_RF;
        end
    endgenerate

    fetch_seq u_fetch_seq (
        .clock       (clock),
        .reset       (reset),
        .ImemReady   (bus.ImemReady),
        .PCSrcE      (PCSrcE),
        .mem_stall   (mem_stall),
        .lw_stall    (lw_stall),
        .imem_req    (imem_req),
        .imem_accept (imem_accept),
        .fetch_wait  (fetch_wait)
    );

    assign bus.ImemReq    = imem_req;
    assign bus.ImemAccept = imem_accept;

    // While reset is held the pipeline is kept full of bubbles with fetch frozen.
    always_comb begin
        StallF    = 1'b1;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reset) begin
            StallM    = mem_stall;
            StallE    = mem_stall;
            StallD    = mem_stall || lw_stall;
            StallF    = mem_stall || lw_stall || (fetch_wait && !PCSrcE);
            FlushW    = mem_stall;
            FlushE    = (lw_stall || PCSrcE) && !mem_stall;
            FlushD    = !mem_stall && (PCSrcE || (fetch_wait && !lw_stall));
            ForwardAE = fwd[0];
            ForwardBE = fwd[1];
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] redirect_cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg    <= '0;
            redirect_cnt_reg <= '0;
        end else begin
            if (StallF && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end
            if (PCSrcE && !mem_stall && (redirect_cnt_reg != '1)) begin
                redirect_cnt_reg <= redirect_cnt_reg + CNT_ONE;
            end
        end
    end

    assign StallCycles   = stall_cnt_reg;
    assign RedirectCount = redirect_cnt_reg;
`else
    assign StallCycles   = '0;
    assign RedirectCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counter expectations follow HAZARD_CTRL_PERF_EN.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCycles, RedirectCount;

    int passed = 0;
    int total  = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .Rs1D          (Rs1D),
        .Rs2D          (Rs2D),
        .Rs1E          (Rs1E),
        .Rs2E          (Rs2E),
        .RdE           (RdE),
        .RdM           (RdM),
        .RdW           (RdW),
        .RegWriteM     (RegWriteM),
        .RegWriteW     (RegWriteW),
        .ResultSrcE0   (ResultSrcE0),
        .PCSrcE        (PCSrcE),
        .bus           (bus),
        .StallF        (StallF),
        .StallD        (StallD),
        .StallE        (StallE),
        .StallM        (StallM),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .FlushW        (FlushW),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .StallCycles   (StallCycles),
        .RedirectCount (RedirectCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s: got %0h expected %0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
        bus.ImemReady = 1'b0; bus.DmemReq = 1'b0; bus.DmemReady = 1'b0;
    endtask

    initial begin
        // Reset: outputs forced even with hazards presented
        clear_inputs();
        reset = 1'b0;
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; bus.ImemReady = 1'b1; PCSrcE = 1'b1;
        #7;
        chk("rst_ImemReq", {31'd0, bus.ImemReq}, 32'd0);
        chk("rst_ImemAccept", {31'd0, bus.ImemAccept}, 32'd0);
        chk("rst_StallF", {31'd0, StallF}, 32'd1);
        chk("rst_StallD", {31'd0, StallD}, 32'd0);
        chk("rst_StallM", {31'd0, StallM}, 32'd0);
        chk("rst_FlushD", {31'd0, FlushD}, 32'd1);
        chk("rst_FlushE", {31'd0, FlushE}, 32'd1);
        chk("rst_FlushW", {31'd0, FlushW}, 32'd1);
        chk("rst_ForwardAE", {30'd0, ForwardAE}, 32'd0);
        chk("rst_StallCycles", StallCycles, 32'd0);

        // Release mid-cycle: still IDLE until the next edge
        clear_inputs();
        reset = 1'b1;
        settle();
        chk("rel_ImemReq_idle", {31'd0, bus.ImemReq}, 32'd0);
        next_cycle();
        chk("rel_ImemReq_first", {31'd0, bus.ImemReq}, 32'd1);
        chk("rel_StallCycles", StallCycles, PERF ? 32'd1 : 32'd0);
        chk("rel_RedirectCount", RedirectCount, 32'd0);

        // Redirect with word ready in REQ
        bus.ImemReady = 1'b1; PCSrcE = 1'b1;
        settle();
        chk("redir_FlushD", {31'd0, FlushD}, 32'd1);
        chk("redir_FlushE", {31'd0, FlushE}, 32'd1);
        chk("redir_StallF", {31'd0, StallF}, 32'd0);
        chk("redir_ImemAccept", {31'd0, bus.ImemAccept}, 32'd1);
        next_cycle();
        PCSrcE = 1'b0;
        settle();
        chk("redir_StallCycles", StallCycles, PERF ? 32'd1 : 32'd0);
        chk("redir_RedirectCount", RedirectCount, PERF ? 32'd1 : 32'd0);
        chk("redir_FlushD_after", {31'd0, FlushD}, 32'd0);

        // Forwarding priority
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
        settle();
        chk("fwd_A_mem", {30'd0, ForwardAE}, 32'd2);
        chk("fwd_B_mem", {30'd0, ForwardBE}, 32'd2);
        RegWriteM = 1'b0;
        settle();
        chk("fwd_A_wb", {30'd0, ForwardAE}, 32'd1);
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        settle();
        chk("fwd_A_x0", {30'd0, ForwardAE}, 32'd0);
        chk("fwd_B_x0", {30'd0, ForwardBE}, 32'd0);
        RdM = 5'd5; RdW = 5'd6; Rs1E = 5'd5; Rs2E = 5'd6;
        settle();
        chk("fwd_A_split", {30'd0, ForwardAE}, 32'd2);
        chk("fwd_B_split", {30'd0, ForwardBE}, 32'd1);
        clear_inputs();

        // Load-use stall for one cycle
        next_cycle();
        bus.ImemReady = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        settle();
        chk("lu_StallF", {31'd0, StallF}, 32'd1);
        chk("lu_StallD", {31'd0, StallD}, 32'd1);
        chk("lu_FlushE", {31'd0, FlushE}, 32'd1);
        chk("lu_FlushD", {31'd0, FlushD}, 32'd0);
        chk("lu_StallE", {31'd0, StallE}, 32'd0);
        chk("lu_ImemAccept", {31'd0, bus.ImemAccept}, 32'd0);
        next_cycle();
        ResultSrcE0 = 1'b0;
        settle();
        chk("lu2_StallF", {31'd0, StallF}, 32'd0);
        chk("lu2_StallD", {31'd0, StallD}, 32'd0);
        chk("lu2_FlushE", {31'd0, FlushE}, 32'd0);
        chk("lu2_ImemAccept", {31'd0, bus.ImemAccept}, 32'd1);
        next_cycle();
        ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        settle();
        chk("lu_x0_StallD", {31'd0, StallD}, 32'd0);
        chk("lu_x0_FlushE", {31'd0, FlushE}, 32'd0);
        clear_inputs();

        // Redirect while waiting for the instruction word
        next_cycle();
        settle();
        chk("rw1_StallF", {31'd0, StallF}, 32'd1);
        chk("rw1_FlushD", {31'd0, FlushD}, 32'd1);
        next_cycle();
        PCSrcE = 1'b1;
        settle();
        chk("rw2_StallF", {31'd0, StallF}, 32'd0);
        chk("rw2_FlushE", {31'd0, FlushE}, 32'd1);
        chk("rw2_FlushD", {31'd0, FlushD}, 32'd1);
        next_cycle();
        PCSrcE = 1'b0;
        settle();
        chk("rw3_StallF", {31'd0, StallF}, 32'd1);
        chk("rw3_ImemAccept", {31'd0, bus.ImemAccept}, 32'd0);
        chk("rw3_ImemReq", {31'd0, bus.ImemReq}, 32'd1);
        next_cycle();
        bus.ImemReady = 1'b1;
        settle();
        chk("rw4_ImemAccept", {31'd0, bus.ImemAccept}, 32'd1);
        chk("rw4_FlushD", {31'd0, FlushD}, 32'd1);
        chk("rw4_StallF", {31'd0, StallF}, 32'd1);
        next_cycle();
        settle();
        chk("rw5_FlushD", {31'd0, FlushD}, 32'd0);
        chk("rw5_StallF", {31'd0, StallF}, 32'd0);
        chk("rw5_ImemAccept", {31'd0, bus.ImemAccept}, 32'd1);
        clear_inputs();

        // Data-memory stall dominates a pending redirect
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.DmemReq = 1'b1; bus.DmemReady = 1'b0; PCSrcE = 1'b1;
            bus.ImemReady = (i < 2);
            settle();
            chk("ms_StallF", {31'd0, StallF}, 32'd1);
            chk("ms_StallD", {31'd0, StallD}, 32'd1);
            chk("ms_StallE", {31'd0, StallE}, 32'd1);
            chk("ms_StallM", {31'd0, StallM}, 32'd1);
            chk("ms_FlushW", {31'd0, FlushW}, 32'd1);
            chk("ms_FlushD", {31'd0, FlushD}, 32'd0);
            chk("ms_FlushE", {31'd0, FlushE}, 32'd0);
            chk("ms_ImemAccept", {31'd0, bus.ImemAccept}, 32'd0);
        end
        next_cycle();
        bus.DmemReady = 1'b1; bus.ImemReady = 1'b1;
        settle();
        chk("msr_FlushD", {31'd0, FlushD}, 32'd1);
        chk("msr_FlushE", {31'd0, FlushE}, 32'd1);
        chk("msr_StallM", {31'd0, StallM}, 32'd0);
        chk("msr_FlushW", {31'd0, FlushW}, 32'd0);
        chk("msr_ImemAccept", {31'd0, bus.ImemAccept}, 32'd1);
        clear_inputs();

        // A redirect during memStall must not start a discard
        next_cycle();
        bus.DmemReq = 1'b1; PCSrcE = 1'b1;
        settle();
        next_cycle();
        clear_inputs();
        bus.ImemReady = 1'b1;
        settle();
        chk("msnd_FlushD", {31'd0, FlushD}, 32'd0);
        chk("msnd_StallF", {31'd0, StallF}, 32'd0);
        clear_inputs();

        // Reset asserted while in DISCARD
        next_cycle();
        PCSrcE = 1'b1;
        settle();
        next_cycle();
        PCSrcE = 1'b0;
        settle();
        chk("rd_ImemReq_pre", {31'd0, bus.ImemReq}, 32'd1);
        reset = 1'b0;
        settle();
        chk("rd_ImemReq", {31'd0, bus.ImemReq}, 32'd0);
        chk("rd_StallF", {31'd0, StallF}, 32'd1);
        chk("rd_FlushE", {31'd0, FlushE}, 32'd1);
        chk("rd_StallCycles", StallCycles, 32'd0);
        chk("rd_RedirectCount", RedirectCount, 32'd0);
        next_cycle();
        chk("rd_hold_StallCycles", StallCycles, 32'd0);
        chk("rd_hold_ImemReq", {31'd0, bus.ImemReq}, 32'd0);
        reset = 1'b1;
        settle();
        chk("rd_rel_ImemReq_idle", {31'd0, bus.ImemReq}, 32'd0);
        next_cycle();
        bus.ImemReady = 1'b1;
        settle();
        chk("rd_rel_ImemReq", {31'd0, bus.ImemReq}, 32'd1);
        chk("rd_rel_FlushD", {31'd0, FlushD}, 32'd0);
        chk("rd_rel_ImemAccept", {31'd0, bus.ImemAccept}, 32'd1);
        chk("rd_rel_StallCycles", StallCycles, PERF ? 32'd1 : 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline controller for the five-stage core. It generates every stall, flush and forward-select signal the datapath consumes. It sequences instruction fetch over a ready/accept handshake with instruction memory, and freezes the pipeline while a data-memory access is outstanding. It sits beside the datapath, reads register indices and control bits from the D/E/M/W stages, and drives the pipeline-register enables and clears.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, performance-counter width

Ports:
- clock  in  1  core clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_W  stage register indices
- RegWriteM, RegWriteW  in  1  destination write-enables in M and W
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch or jump resolved in E
- ImemReady  in  1  instruction word valid; held stable until accepted
- DmemReq, DmemReady  in  1  M-stage memory access pending / completes this cycle
- ImemReq  out  1  fetch request active
- ImemAccept  out  1  instruction word consumed this cycle
- StallF, StallD, StallE, StallM  out  1  hold the stage register
- FlushD, FlushE, FlushW  out  1  clear the stage register (bubble)
- ForwardAE, ForwardBE  out  2  ALU operand source select
- StallCycles, RedirectCount  out  CNT_W  performance counters

## Operation
- Forwarding, shown for A; B is identical using Rs2E:
  - 2'b10 if RegWriteM & RdM!=0 & RdM==Rs1E
  - else 2'b01 if RegWriteW & RdW!=0 & RdW==Rs1E
  - else 2'b00
  - M has priority over W.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = DmemReq & ~DmemReady.
- Fetch FSM states: IDLE, REQ, DISCARD.
  - IDLE -> REQ unconditionally on the first edge after reset release.
  - REQ -> DISCARD when ~ImemReady & PCSrcE & ~memStall.
  - REQ otherwise stays in REQ.
  - DISCARD -> REQ when ImemReady, else stays in DISCARD.
- ImemReq = (state != IDLE).
- fetchWait = (state != REQ) | ~ImemReady.
- ImemAccept = ImemReady & (state==DISCARD | (state==REQ & ~memStall & ~lwStall)).
- Stall outputs:
  - StallM = StallE = memStall
  - StallD = memStall | lwStall
  - StallF = memStall | lwStall | (fetchWait & ~PCSrcE)
- Flush outputs:
  - FlushW = memStall
  - FlushE = (lwStall | PCSrcE) & ~memStall
  - FlushD = ~memStall & (PCSrcE | (fetchWait & ~lwStall))
- memStall has top priority: a PCSrcE raised while memStall is asserted is ignored, because E is frozen and the redirect is re-presented when the stall clears.
- PCSrcE while in DISCARD: the PC loads the new target and the FSM stays in DISCARD.
- A word accepted in DISCARD is dropped by FlushD.

## Timing
- Stall, flush, forward and ImemAccept outputs are combinational from inputs and state, valid in the same cycle.
- FSM state and counters are registered.
- While reset is low, all of the following are forced and held regardless of inputs:
  - state = IDLE, ImemReq = 0, ImemAccept = 0
  - StallF = 1, StallD = StallE = StallM = 0
  - FlushD = FlushE = FlushW = 1
  - ForwardAE = ForwardBE = 2'b00
  - counters = 0
- The first ImemReq is the first cycle after reset deasserts.
- The minimum fetch latency is 1 cycle: ImemReady in the request cycle is accepted immediately.
- A load-use stall lasts exactly 1 cycle, because the load advances to M on the next edge.
- Reset asserted mid-DISCARD or mid-memStall returns the FSM to IDLE asynchronously. Any in-flight memory word is abandoned.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - StallCycles increments every cycle StallF=1.
  - RedirectCount increments every cycle PCSrcE & ~memStall.
  - Both counters saturate at all-ones.
- Undefined: no counter logic is built, and both counter ports are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - fetch-state enum fetch_state_t {IDLE, REQ, DISCARD}
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- One sub-module, fetch_seq: the fetch FSM plus ImemReq, ImemAccept and fetchWait.
- Forwarding, stall and flush logic stays in hazard_ctrl.

## Test plan
- Forward priority: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10. Drop RegWriteM -> 2'b01. RdM=RdW=0 -> 2'b00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0. With RdE=0 -> no stall.
- Redirect: REQ state, ImemReady=1, PCSrcE=1 -> FlushD=FlushE=1, StallF=0, ImemAccept=1.
- Fetch redirect while waiting: ImemReady=0 for 3 cycles with PCSrcE=1 in cycle 2 -> DISCARD. The next ImemReady gives ImemAccept=1 and FlushD=1, then the FSM returns to REQ.
- Data-memory stall: DmemReq=1, DmemReady=0 for 4 cycles with PCSrcE=1 -> StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0, ImemAccept=0. On the cycle DmemReady=1, FlushD=FlushE=1.
- Reset mid-operation: reset low during DISCARD with HAZARD_CTRL_PERF_EN -> IDLE, counters 0. ImemReq rises on the first cycle after release.
